// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and frame-length helper,
// kept here so the receiver can reuse them.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } uart_state_e;

  // Clock cycles from the first start-bit cycle through the last stop-bit cycle.
  function automatic int frame_len(input int dbits, input int clks_per_bit,
                                   input int parity_en, input int stop_bits);
    return clks_per_bit * (1 + dbits + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps,
// held at zero while clear is high. bit_tick marks the last cycle of a bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic                            clear,
  output logic [$clog2(CLKS_PER_BIT)-1:0] count,
  output logic                            bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign bit_tick = (count_q == LAST);
  assign count    = count_q;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || bit_tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame from the data FIFO and
// sends start, LSB-first data, optional parity and stop bits on tx.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DBits        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [DBits-1:0] fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic             tx_enable,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DBits) + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] LAST_DATA = IW'(DBits - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [DBits-1:0] shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CW-1:0]    bit_count;
  logic             bit_tick;
  logic             timer_clear;

  // The timer only runs while a frame is on the line, so START begins at count 0.
  assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_LATCH);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .areset  (areset),
    .clear   (timer_clear),
    .count   (bit_count),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) state_d = ST_REQ;
      end
      ST_REQ: state_d = ST_LATCH;
      ST_LATCH: begin
        shift_d   = fifo_data;
        parity_d  = (PARITY_ODD != 0) ? ~^fifo_data : ^fifo_data;
        bit_idx_d = '0;
        state_d   = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        // frame_done is registered, so raise it one cycle ahead of the final stop cycle.
        if ((bit_idx_q == LAST_STOP) && (bit_count == PRE_LAST)) done_d = 1'b1;
        if (bit_tick) begin
          if (bit_idx_q == LAST_STOP) begin
            bit_idx_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered so tx changes on the bit boundary.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en = (state_q == ST_REQ);
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: reset, single and back-to-back frames,
// parity variants, mid-frame reset and tx_enable gating.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       areset;
  logic       tx_enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en, tx, busy, frame_done;

  logic       p_enable, p_empty;
  logic [7:0] p_data;
  logic       pe_rd, pe_tx, pe_busy, pe_done;
  logic       po_rd, po_tx, po_busy, po_done;

  int         n_assert  = 0;
  int         n_fail    = 0;
  int         cyc       = 0;
  int         rd_pulses = 0;
  logic [7:0] fq[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(.DBits(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .areset(areset), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .tx_enable(tx_enable), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_uart_tx #(.DBits(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_par_even (
    .clk(clk), .areset(areset), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_rd_en(pe_rd), .tx_enable(p_enable), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_done)
  );

  fifo_uart_tx #(.DBits(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_par_odd (
    .clk(clk), .areset(areset), .fifo_data(p_data), .fifo_empty(p_empty),
    .fifo_rd_en(po_rd), .tx_enable(p_enable), .tx(po_tx), .busy(po_busy), .frame_done(po_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clock and sample 1 ns later; also plays the FIFO for u_dut.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (fifo_rd_en === 1'b1) begin
      rd_pulses++;
      if (fq.size() > 0) fifo_data = fq.pop_front();
      fifo_empty = (fq.size() == 0);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int at);
    int n = 0;
    while (tx !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_start"}, {31'd0, tx}, 32'd0);
    at = cyc;
  endtask

  // Expects to be in frame cycle 1; bits[0] is the start bit, bits[nbits-1] the stop bit.
  task automatic check_frame(input string tag, input logic [11:0] bits, input int nbits, input int drop_at);
    for (int c = 0; c < nbits * 4; c++) begin
      if (c == drop_at) tx_enable = 1'b0;
      chk({tag, "_tx"}, {31'd0, tx}, {31'd0, bits[c/4]});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, frame_done}, {31'd0, (c == nbits * 4 - 1)});
      step();
    end
  endtask

  initial begin
    int         c0, s1, s2, dcnt;
    logic [10:0] ebits, obits;

    // 1: reset with arbitrary inputs
    areset = 1'b1; tx_enable = 1'b1; fifo_empty = 1'b0; fifo_data = 8'h3C;
    p_enable = 1'b0; p_empty = 1'b1; p_data = 8'h07;
    step(); step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    fifo_empty = 1'b1; tx_enable = 1'b0;
    areset = 1'b0;
    step();

    // 2: single word 0xA5
    rd_pulses = 0;
    push(8'hA5); tx_enable = 1'b1; c0 = cyc;
    wait_start("t2", s1);
    chk("t2_latency", s1 - c0, 32'd3);
    chk("t2_rd_pulses", rd_pulses, 32'd1);
    check_frame("t2", {2'b00, 1'b1, 8'hA5, 1'b0}, 10, -1);
    chk("t2_busy_after", {31'd0, busy}, 32'd0);
    chk("t2_tx_after", {31'd0, tx}, 32'd1);
    chk("t2_done_after", {31'd0, frame_done}, 32'd0);

    // 3: back-to-back 0x00, 0xFF
    rd_pulses = 0;
    push(8'h00); push(8'hFF);
    wait_start("t3a", s1);
    check_frame("t3a", {2'b00, 1'b1, 8'h00, 1'b0}, 10, -1);
    wait_start("t3b", s2);
    chk("t3_spacing", s2 - s1, 32'd43);
    check_frame("t3b", {2'b00, 1'b1, 8'hFF, 1'b0}, 10, -1);
    chk("t3_rd_pulses", rd_pulses, 32'd2);
    chk("t3_busy_after", {31'd0, busy}, 32'd0);

    // 4: parity even/odd on 0x07 (three ones)
    ebits = {1'b1, 1'b1, 8'h07, 1'b0};
    obits = {1'b1, 1'b0, 8'h07, 1'b0};
    p_empty = 1'b0; p_enable = 1'b1;
    step();
    chk("t4_even_rd", {31'd0, pe_rd}, 32'd1);
    chk("t4_odd_rd", {31'd0, po_rd}, 32'd1);
    p_empty = 1'b1;
    step();
    chk("t4_even_latch_tx", {31'd0, pe_tx}, 32'd1);
    step();
    for (int c = 0; c < 44; c++) begin
      chk("t4_even_tx", {31'd0, pe_tx}, {31'd0, ebits[c/4]});
      chk("t4_odd_tx", {31'd0, po_tx}, {31'd0, obits[c/4]});
      chk("t4_even_done", {31'd0, pe_done}, {31'd0, (c == 43)});
      chk("t4_odd_done", {31'd0, po_done}, {31'd0, (c == 43)});
      step();
    end
    chk("t4_even_busy_after", {31'd0, pe_busy}, 32'd0);
    chk("t4_odd_busy_after", {31'd0, po_busy}, 32'd0);
    p_enable = 1'b0;

    // 5: reset during the third data bit of 0x3B (bit2 = 0)
    push(8'h3B);
    wait_start("t5a", s1);
    for (int i = 0; i < 12; i++) step();
    chk("t5_bit2_tx", {31'd0, tx}, 32'd0);
    chk("t5_bit2_busy", {31'd0, busy}, 32'd1);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("t5_rst_tx", {31'd0, tx}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_done === 1'b1) dcnt++;
      step();
    end
    chk("t5_no_done", dcnt, 32'd0);
    chk("t5_idle_tx", {31'd0, tx}, 32'd1);
    push(8'h5A); c0 = cyc;
    wait_start("t5b", s1);
    chk("t5_latency", s1 - c0, 32'd3);
    check_frame("t5b", {2'b00, 1'b1, 8'h5A, 1'b0}, 10, -1);

    // 6: tx_enable gating
    tx_enable = 1'b0; rd_pulses = 0;
    push(8'h55);
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_rd", rd_pulses, 32'd0);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);
    tx_enable = 1'b1;
    wait_start("t6", s1);
    push(8'h66);
    check_frame("t6", {2'b00, 1'b1, 8'h55, 1'b0}, 10, 20);
    for (int i = 0; i < 20; i++) step();
    chk("t6_rd_pulses", rd_pulses, 32'd1);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);
    chk("t6_tx_after", {31'd0, tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
